// File: rtl/bw_io_misc_pkg.sv
// Shared types for the misc-pad chunk: boundary-scan op encoding and its decode.
// Pure declarations with no timing and no flow control.
package bw_io_misc_pkg;

  localparam int BSR_CELLS_PER_PAD = 2;

  typedef enum logic [1:0] {
    BSR_HOLD    = 2'd0,
    BSR_CAPTURE = 2'd1,
    BSR_SHIFT   = 2'd2
  } bsr_op_e;

  function automatic bsr_op_e bsr_decode(input logic clock_dr, input logic shift_dr);
    if (!clock_dr) return BSR_HOLD;
    if (shift_dr)  return BSR_SHIFT;
    return BSR_CAPTURE;
  endfunction

endpackage

// File: rtl/bw_io_bsr_cell.sv
// One boundary-scan cell: a capture/shift flop plus an update flop.
// Both flops change on the clock edge after the strobe. The cell is strobe driven and has no backpressure.
module bw_io_bsr_cell
  import bw_io_misc_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  bsr_op_e op,
  input  logic    update_en,
  input  logic    capture_in,
  input  logic    shift_in,
  output logic    shift_q,
  output logic    update_q
);

  logic shift_d;
  logic update_d;

  always_comb begin
    shift_d = shift_q;
    case (op)
      BSR_CAPTURE: shift_d = capture_in;
      BSR_SHIFT:   shift_d = shift_in;
      default:     shift_d = shift_q;
    endcase
    // Update always samples the pre-edge shift value, even during a shift.
    update_d = update_en ? shift_q : update_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q  <= 1'b0;
      update_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      update_q <= update_d;
    end
  end

endmodule

// File: rtl/bw_io_misc_chunk_gen.sv
// Misc-pad chunk: registered pad drive, input synchronisers, BSR, internal scan, trigger counter.
// Drive latency is 1 and input latency is SYNC_STAGES. The chunk has no backpressure, and the trigger counter saturates.
module bw_io_misc_chunk_gen
  import bw_io_misc_pkg::*;
#(
  parameter int                  NUM_PADS    = 4,
  parameter logic [NUM_PADS-1:0] OUT_EN      = 4'b1101,
  parameter int                  SYNC_STAGES = 2,
  parameter int                  TRIG_IDX    = 1,
  parameter int                  TRIG_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_PADS-1:0]   data,
  input  logic [NUM_PADS-1:0]   oe,
  output logic [NUM_PADS-1:0]   to_core,
  input  logic [NUM_PADS-1:0]   pad_in,
  output logic [NUM_PADS-1:0]   pad_out,
  output logic [NUM_PADS-1:0]   pad_oe,
  input  logic                  hiz_l,
  input  logic                  mode_ctl,
  input  logic                  clock_dr,
  input  logic                  shift_dr,
  input  logic                  update_dr,
  input  logic                  bsi,
  output logic                  bso,
  input  logic                  se,
  input  logic                  si,
  output logic                  so,
  output logic                  trig_pulse,
  output logic [TRIG_CNT_W-1:0] trig_cnt,
  input  logic                  trig_clr
);

  localparam int CHAIN_LEN = NUM_PADS * (2 + SYNC_STAGES);
  localparam int BSR_LEN   = NUM_PADS * BSR_CELLS_PER_PAD;

  logic [NUM_PADS-1:0]                  dq_q, dq_d;
  logic [NUM_PADS-1:0]                  oq_q, oq_d;
  logic [NUM_PADS-1:0][SYNC_STAGES-1:0] sync_q, sync_d, sync_fn;
  logic [CHAIN_LEN-1:0]                 scan_cur, scan_nxt;

  logic                  prev_q, prev_d;
  logic                  pulse_q, pulse_d;
  logic [TRIG_CNT_W-1:0] cnt_q, cnt_d;
  logic                  trig_cur, trig_edge;

  logic [BSR_LEN-1:0] bsr_sh_q;
  logic [BSR_LEN-1:0] bsr_upd_q;
  bsr_op_e            bsr_op;

  // The packed concatenation places dq[0] at bit 0, so the chain runs si -> dq -> oq -> sync -> so.
  always_comb begin
    scan_cur = {sync_q, oq_q, dq_q};
    scan_nxt = {scan_cur[CHAIN_LEN-2:0], si};
    for (int p = 0; p < NUM_PADS; p++) begin
      sync_fn[p][0] = pad_in[p];
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_fn[p][s] = sync_q[p][s-1];
      end
    end
    if (se) begin
      {sync_d, oq_d, dq_d} = scan_nxt;
    end else begin
      {sync_d, oq_d, dq_d} = {sync_fn, oe, data};
    end
  end

  always_comb begin
    trig_cur  = sync_q[TRIG_IDX][SYNC_STAGES-1];
    trig_edge = trig_cur & ~prev_q;
    prev_d    = prev_q;
    pulse_d   = 1'b0;
    cnt_d     = cnt_q;
    if (!se) begin
      prev_d  = trig_cur;
      pulse_d = trig_edge;
      if (trig_clr) begin
        cnt_d = '0;
      end else if (trig_edge && (cnt_q != {TRIG_CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dq_q    <= '0;
      oq_q    <= '0;
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      dq_q    <= dq_d;
      oq_q    <= oq_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bsr_op = bsr_decode(clock_dr, shift_dr);

  for (genvar c = 0; c < BSR_LEN; c++) begin : g_bsr
    localparam int PAD = c / BSR_CELLS_PER_PAD;
    logic cap_in;
    logic sh_in;
    if (c % BSR_CELLS_PER_PAD == 0) begin : g_oe_cell
      assign cap_in = oq_q[PAD];
    end else begin : g_data_cell
      assign cap_in = pad_in[PAD];
    end
    if (c == 0) begin : g_head
      assign sh_in = bsi;
    end else begin : g_body
      assign sh_in = bsr_sh_q[c-1];
    end
    bw_io_bsr_cell u_cell (
      .clk        (clk),
      .reset      (reset),
      .op         (bsr_op),
      .update_en  (update_dr),
      .capture_in (cap_in),
      .shift_in   (sh_in),
      .shift_q    (bsr_sh_q[c]),
      .update_q   (bsr_upd_q[c])
    );
  end

  // In EXTEST the update registers replace the core stage. Both hiz_l and the pad capability still gate the driver.
  always_comb begin
    for (int i = 0; i < NUM_PADS; i++) begin
      pad_out[i] = mode_ctl ? bsr_upd_q[BSR_CELLS_PER_PAD*i+1] : dq_q[i];
      pad_oe[i]  = (mode_ctl ? bsr_upd_q[BSR_CELLS_PER_PAD*i] : oq_q[i]) & OUT_EN[i] & hiz_l;
      to_core[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  assign bso        = bsr_sh_q[BSR_LEN-1];
  assign so         = scan_cur[CHAIN_LEN-1];
  assign trig_pulse = pulse_q;
  assign trig_cnt   = cnt_q;

endmodule

// File: tb/tb_bw_io_misc_chunk_gen.sv
// Scoreboarded bench for bw_io_misc_chunk_gen. It pairs directed scenarios with random traffic
// and checks them against a cycle-level reference model.
module tb_bw_io_misc_chunk_gen;

  localparam int N = 4;
  localparam int S = 2;
  localparam int T = 1;
  localparam int L = N * (2 + S);
  localparam int B = 2 * N;
  localparam logic [N-1:0] EN_MASK = 4'b1101;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] data, oe, pad_in;
  logic [N-1:0] to_core, pad_out, pad_oe;
  logic hiz_l, mode_ctl, clock_dr, shift_dr, update_dr, bsi, se, si, trig_clr;
  logic bso, so, trig_pulse;
  logic [7:0] trig_cnt;

  always #5 clk = ~clk;

  bw_io_misc_chunk_gen #(
    .NUM_PADS(N), .OUT_EN(EN_MASK), .SYNC_STAGES(S), .TRIG_IDX(T), .TRIG_CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .data(data), .oe(oe), .to_core(to_core), .pad_in(pad_in),
    .pad_out(pad_out), .pad_oe(pad_oe), .hiz_l(hiz_l), .mode_ctl(mode_ctl),
    .clock_dr(clock_dr), .shift_dr(shift_dr), .update_dr(update_dr), .bsi(bsi), .bso(bso),
    .se(se), .si(si), .so(so), .trig_pulse(trig_pulse), .trig_cnt(trig_cnt), .trig_clr(trig_clr)
  );

  typedef struct {
    logic [N-1:0] pad_out;
    logic [N-1:0] pad_oe;
    logic [N-1:0] to_core;
    logic         bso;
    logic         so;
    logic         pulse;
    logic [7:0]   cnt;
  } exp_t;

  exp_t exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  // Reference state. The sync pipeline for each pad holds the newest sample in element 0.
  logic [N-1:0]        m_dq = '0, m_oq = '0;
  logic [N-1:0][S-1:0] m_sync = '0;
  logic [B-1:0]        m_sh = '0, m_upd = '0;
  logic                m_prev = 1'b0, m_pulse = 1'b0;
  int                  m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void push_exp();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.pad_out[i] = mode_ctl ? m_upd[2*i+1] : m_dq[i];
      e.pad_oe[i]  = (mode_ctl ? m_upd[2*i] : m_oq[i]) & EN_MASK[i] & hiz_l;
      e.to_core[i] = m_sync[i][S-1];
    end
    e.bso   = m_sh[B-1];
    e.so    = m_sync[N-1][S-1];
    e.pulse = m_pulse;
    e.cnt   = 8'(m_cnt);
    exp_q.push_back(e);
  endfunction

  function automatic void model_step();
    logic [B-1:0] sh_old;
    logic [L-1:0] flat;
    logic cur;
    if (reset) begin
      m_dq = '0; m_oq = '0; m_sync = '0; m_sh = '0; m_upd = '0;
      m_prev = 1'b0; m_pulse = 1'b0; m_cnt = 0;
      return;
    end
    sh_old = m_sh;
    if (clock_dr && !shift_dr) begin
      for (int i = 0; i < N; i++) begin
        m_sh[2*i]   = m_oq[i];
        m_sh[2*i+1] = pad_in[i];
      end
    end else if (clock_dr) begin
      m_sh = {sh_old[B-2:0], bsi};
    end
    if (update_dr) m_upd = sh_old;
    cur = m_sync[T][S-1];
    if (!se) begin
      m_pulse = cur & ~m_prev;
      m_prev  = cur;
      if (trig_clr) m_cnt = 0;
      else if (m_pulse && m_cnt < 255) m_cnt = m_cnt + 1;
      m_dq = data;
      m_oq = oe;
      for (int p = 0; p < N; p++) m_sync[p] = {m_sync[p][S-2:0], pad_in[p]};
    end else begin
      m_pulse = 1'b0;
      flat = {m_sync, m_oq, m_dq};
      flat = {flat[L-2:0], si};
      {m_sync, m_oq, m_dq} = flat;
    end
  endfunction

  task automatic tick();
    push_exp();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    data = '0; oe = '0; pad_in = '0; hiz_l = 1'b1; mode_ctl = 1'b0;
    clock_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0; bsi = 1'b0;
    se = 1'b0; si = 1'b0; trig_clr = 1'b0;
  endtask

  task automatic rand_inputs();
    data = 4'($urandom); oe = 4'($urandom); pad_in = 4'($urandom);
    hiz_l = ($urandom_range(0, 7) != 0); mode_ctl = 1'($urandom);
    clock_dr = 1'($urandom); shift_dr = 1'($urandom); update_dr = ($urandom_range(0, 3) == 0);
    bsi = 1'($urandom); si = 1'($urandom);
    se = ($urandom_range(0, 7) == 0);
    trig_clr = se ? 1'b0 : ($urandom_range(0, 15) == 0);
  endtask

  // The monitor compares every field the DUT presents against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pad_out",    32'(pad_out),    32'(e.pad_out));
      chk("pad_oe",     32'(pad_oe),     32'(e.pad_oe));
      chk("to_core",    32'(to_core),    32'(e.to_core));
      chk("bso",        32'(bso),        32'(e.bso));
      chk("so",         32'(so),         32'(e.so));
      chk("trig_pulse", 32'(trig_pulse), 32'(e.pulse));
      chk("trig_cnt",   32'(trig_cnt),   32'(e.cnt));
    end
  end

  initial begin
    logic [7:0] pat;
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    model_step();
    #1;

    for (int k = 0; k < 3; k++) begin
      rand_inputs();
      tick();
    end

    idle_inputs();
    reset = 1'b0;
    data = 4'hA; oe = 4'hF;
    tick();
    tick();
    hiz_l = 1'b0;
    tick();
    hiz_l = 1'b1;
    tick();

    // Capture, then shift the whole register out.
    pad_in = 4'b0101; oe = 4'($urandom);
    tick();
    clock_dr = 1'b1; shift_dr = 1'b0;
    tick();
    shift_dr = 1'b1; bsi = 1'b0;
    for (int k = 0; k < B; k++) tick();

    // Load a pattern, update it, and drive the pads from the BSR.
    pat = 8'b1011_0011;
    for (int k = B - 1; k >= 0; k--) begin
      bsi = pat[k];
      tick();
    end
    clock_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b1;
    tick();
    update_dr = 1'b0; mode_ctl = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data = 4'($urandom); oe = 4'($urandom);
      tick();
    end
    clock_dr = 1'b1; shift_dr = 1'b1; update_dr = 1'b1; bsi = 1'b1;
    tick();
    clock_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
    tick();
    tick();
    mode_ctl = 1'b0;

    // Drive the internal scan chain through twice its length.
    se = 1'b1;
    for (int k = 0; k < 2 * L; k++) begin
      si = 1'($urandom); data = 4'($urandom); oe = 4'($urandom); pad_in = 4'($urandom);
      tick();
    end
    se = 1'b0;
    tick();

    // Apply 300 rising edges on the trigger pad, enough to saturate the counter.
    for (int k = 0; k < 300; k++) begin
      pad_in = 4'($urandom); pad_in[T] = 1'b1;
      tick(); tick();
      pad_in[T] = 1'b0;
      tick(); tick();
    end
    for (int k = 0; k < 4; k++) tick();
    trig_clr = 1'b1;
    tick();
    trig_clr = 1'b0;
    for (int k = 0; k < 4; k++) tick();

    // Assert reset while a shift is in progress.
    clock_dr = 1'b1; shift_dr = 1'b1; bsi = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    reset = 1'b1; update_dr = 1'b1;
    tick();
    reset = 1'b0; clock_dr = 1'b0; update_dr = 1'b0; mode_ctl = 1'b1;
    tick();
    tick();

    for (int k = 0; k < 600; k++) begin
      rand_inputs();
      reset = ($urandom_range(0, 63) == 0);
      tick();
    end
    reset = 1'b0;

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
